// File: rtl/piggy_bank_ctrl.sv
// piggy_bank_ctrl: shares one balance register between round-robin coin credits and a withdraw port.
// Define PB_AUDIT_EN to add the o_credit_count / o_debit_count audit counters.
module piggy_bank_ctrl #(
    parameter int unsigned            NUM_SLOTS = 4,
    parameter int unsigned            BAL_W     = 16,
    parameter int unsigned            PEND_W    = 3,
    parameter int unsigned            WDR_W     = 8,
    parameter logic [8*NUM_SLOTS-1:0] DENOM     = 32'h0A050201
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_SLOTS-1:0] i_coin,
    input  logic                 i_wdr_req,
    input  logic [WDR_W-1:0]     i_wdr_amt,
    output logic                 o_wdr_ack,
    output logic                 o_wdr_nack,
    output logic [BAL_W-1:0]     o_balance,
    output logic                 o_credit_pulse,
    output logic                 o_coin_drop,
    output logic                 o_overflow_err
`ifdef PB_AUDIT_EN
    ,
    output logic [15:0]          o_credit_count,
    output logic [15:0]          o_debit_count
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, CREDIT, DEBIT, WDONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_SLOTS-1:0] r_coin_prev;
    logic [PEND_W-1:0]    r_pend [NUM_SLOTS];
    logic [IDX_W-1:0]     r_rr;
    logic [IDX_W-1:0]     r_slot;
    logic [WDR_W-1:0]     r_amt;
    logic [BAL_W-1:0]     r_balance;
    logic                 r_wdr_ack;
    logic                 r_wdr_nack;
    logic                 r_credit_pulse;
    logic                 r_coin_drop;
    logic                 r_overflow_err;

    logic [NUM_SLOTS-1:0] w_evt;
    logic [NUM_SLOTS-1:0] w_full;
    logic [NUM_SLOTS-1:0] w_grant_vec;
    logic                 w_found;
    logic                 w_grant;
    logic                 w_latch_amt;
    logic                 w_drop;
    logic                 w_cover;
    logic                 w_sat;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_rr_nxt;
    logic [BAL_W-1:0]     w_denom;
    logic [BAL_W-1:0]     w_amt_ext;
    logic [BAL_W:0]       w_sum;

    assign w_evt = i_coin & ~r_coin_prev;

    // Round-robin search: slots at or above the pointer first, then wrap to the low slots.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_full      = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            w_full[i] = (r_pend[i] == '1);
            if (!w_found && (i >= 32'(r_rr)) && (r_pend[i] != '0)) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!w_found && (i < 32'(r_rr)) && (r_pend[i] != '0)) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_latch_amt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_wdr_req) begin
                    w_latch_amt = 1'b1;
                    w_state_nxt = DEBIT;
                end else if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = CREDIT;
                end
            end
            CREDIT:  w_state_nxt = IDLE;
            DEBIT:   w_state_nxt = WDONE;
            WDONE:   if (!i_wdr_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_vec = '0;
        if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
    end

    assign w_drop    = |(w_evt & w_full & ~w_grant_vec);
    assign w_rr_nxt  = (w_grant_idx == IDX_W'(NUM_SLOTS - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_denom   = BAL_W'(DENOM[8*r_slot +: 8]);
    assign w_sum     = {1'b0, r_balance} + {1'b0, w_denom};
    assign w_sat     = w_sum[BAL_W];
    assign w_amt_ext = BAL_W'(r_amt);
    assign w_cover   = (w_amt_ext <= r_balance);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_coin_prev    <= '0;
            r_rr           <= '0;
            r_slot         <= '0;
            r_amt          <= '0;
            r_balance      <= '0;
            r_wdr_ack      <= 1'b0;
            r_wdr_nack     <= 1'b0;
            r_credit_pulse <= 1'b0;
            r_coin_drop    <= 1'b0;
            r_overflow_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) r_pend[i] <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_coin_prev    <= i_coin;
            r_wdr_ack      <= 1'b0;
            r_wdr_nack     <= 1'b0;
            r_credit_pulse <= 1'b0;
            r_coin_drop    <= w_drop;
            // A same-cycle edge and grant on one slot cancel, so a full counter never drops then.
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (w_evt[i] && !w_grant_vec[i]) begin
                    if (!w_full[i]) r_pend[i] <= r_pend[i] + PEND_W'(1);
                end else if (!w_evt[i] && w_grant_vec[i]) begin
                    r_pend[i] <= r_pend[i] - PEND_W'(1);
                end
            end
            if (w_grant) begin
                r_slot <= w_grant_idx;
                r_rr   <= w_rr_nxt;
            end
            if (w_latch_amt) r_amt <= i_wdr_amt;
            case (r_state)
                CREDIT: begin
                    r_balance      <= w_sat ? '1 : w_sum[BAL_W-1:0];
                    r_credit_pulse <= 1'b1;
                    if (w_sat) r_overflow_err <= 1'b1;
                end
                DEBIT: begin
                    if (w_cover) begin
                        r_balance <= r_balance - w_amt_ext;
                        r_wdr_ack <= 1'b1;
                    end else begin
                        r_wdr_nack <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wdr_ack      = r_wdr_ack;
    assign o_wdr_nack     = r_wdr_nack;
    assign o_balance      = r_balance;
    assign o_credit_pulse = r_credit_pulse;
    assign o_coin_drop    = r_coin_drop;
    assign o_overflow_err = r_overflow_err;

`ifdef PB_AUDIT_EN
    logic [15:0] r_credit_count;
    logic [15:0] r_debit_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_credit_count <= '0;
            r_debit_count  <= '0;
        end else begin
            if (r_state == CREDIT)           r_credit_count <= r_credit_count + 16'd1;
            if (r_state == DEBIT && w_cover) r_debit_count  <= r_debit_count + 16'd1;
        end
    end

    assign o_credit_count = r_credit_count;
    assign o_debit_count  = r_debit_count;
`else
    // Default build carries no audit state.
`endif

endmodule
